perf_mon: RTL and testbench
===========================

PERF_MON -- requirements
Module: perf_mon

Interface
REQ-001 Parameter CH, default 4, number of busy channels monitored (legal 1..12).
REQ-002 Parameter CNT_W, default 32, counter width in bits (legal 8..32).
REQ-003 clk  input  1  sole clock; every flop is rising-edge clocked.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 ready  input  1  system-ready qualifier; counting is allowed only while high.
REQ-006 busy  input  CH  per-channel busy strobes, sampled every clk.
REQ-007 evb_cmd_request  input  1  EVB command valid; held high until finish.
REQ-008 evb_cmd_addr  input  4  EVB register index.
REQ-009 evb_cmd_wr_mask  input  2  2'b00 = read; any nonzero value = 32-bit write.
REQ-010 evb_cmd_wr_data  input  32  write data.
REQ-011 evb_cmd_finish  output  1  one-cycle command completion pulse.
REQ-012 evb_cmd_rd_data  output  32  read data, valid while finish is high, else 0.
REQ-013 irq  output  1  threshold interrupt (present only with PERF_MON_IRQ_EN).

Function
REQ-014 Live counters: TOTAL plus CH[i] for i = 0..CH-1, each CNT_W bits wide and not EVB-visible.
REQ-015 Register map: 0 CTRL (bit0 EN, bit1 CLR, bit2 SNAP); 1 TOTAL_SNAP; 2..2+CH-1 CH_SNAP[i]; 14 THRESH; 15 STATUS (bit i = CH[i] overflow, bit 15 = TOTAL overflow, bit 16 = irq pending).
REQ-016 Each cycle with EN=1 and ready=1: TOTAL increments by 1, and CH[i] increments by 1 when busy[i]=1.
REQ-017 When ready=0, all live counters clear to 0 on the next edge; snapshots, STATUS, CTRL and THRESH hold.
REQ-018 Saturation: a counter at all-ones holds that value and sets its sticky STATUS overflow bit; no wrap.
REQ-019 CLR write: live counters and STATUS clear on the next edge; CLR takes priority over increment that cycle; the CLR bit self-clears and reads 0.
REQ-020 SNAP write: all live counters copy atomically into the snapshot registers on the same edge; SNAP self-clears and reads 0.
REQ-021 SNAP and CLR in one write: the snapshot captures the pre-clear values.
REQ-022 EVB handshake: finish asserts exactly one cycle after request is first sampled, lasts one cycle; a new command is accepted only after request deasserts for at least one cycle.
REQ-023 A write takes effect on the edge on which finish is driven high.
REQ-024 Reads return the register zero-extended to 32 bits.
REQ-025 Reads of unmapped addresses (2+CH..13) return 0; writes to them and to snapshot or STATUS addresses are ignored.

Reset
REQ-026 On rst_n low: all counters, snapshots, STATUS, CTRL, THRESH, finish, rd_data and irq go to 0 immediately, without waiting for clk.
REQ-027 Reset mid-command aborts the command; no finish pulse follows reset release.

Configuration
REQ-028 Macro PERF_MON_IRQ_EN defined: THRESH is writable, and when TOTAL equals THRESH (THRESH != 0) while counting, STATUS bit16 sets and irq goes high and stays high until a STATUS write with bit16=1 or a CLR.
REQ-029 PERF_MON_IRQ_EN undefined: irq port is absent, THRESH reads 0 and ignores writes, and STATUS bit16 reads 0.

Verification
REQ-030 Reset, write CTRL=1, ready=1, busy=4'b0101 for 100 cycles, SNAP -> TOTAL_SNAP=100, CH_SNAP0=100, CH_SNAP1=0, CH_SNAP2=100, CH_SNAP3=0.
REQ-031 CNT_W=8, EN=1, busy[0]=1 for 300 cycles, SNAP -> CH_SNAP0=255, TOTAL_SNAP=255, STATUS=0x0000_8001.
REQ-032 Counters at 50, write CTRL=0x7 -> snapshot regs read 50; a second SNAP reads 1 (one count after clear); STATUS=0.
REQ-033 ready drops for 1 cycle at count 20, then rises; after 10 more cycles, SNAP -> TOTAL_SNAP=10; earlier snapshot values are unchanged until that SNAP.
REQ-034 Read addr 13 with CH=4 -> rd_data=0, finish exactly one cycle after request; rst_n pulsed low mid-request -> finish never asserts and all registers read 0.
REQ-035 With PERF_MON_IRQ_EN, THRESH=16, EN=1 -> irq rises on the cycle TOTAL reaches 16; STATUS write 0x10000 -> irq low next cycle.

Source files
------------

// File: rtl/perf_mon.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | perf_mon : busy-cycle performance counters with EVB register access.      |
// | Define PERF_MON_IRQ_EN for the THRESH register and irq output. Rev 1.0    |
// +--------------------------------------------------------------------------+
module perf_mon #(
  parameter int CH    = 4,
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ready,
  input  logic [CH-1:0] busy,
  input  logic          evb_cmd_request,
  input  logic [3:0]    evb_cmd_addr,
  input  logic [1:0]    evb_cmd_wr_mask,
  input  logic [31:0]   evb_cmd_wr_data,
  output logic          evb_cmd_finish,
  output logic [31:0]   evb_cmd_rd_data
`ifdef PERF_MON_IRQ_EN
  ,
  output logic          irq
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [3:0]       A_CTRL   = 4'd0;
  localparam logic [3:0]       A_TOTAL  = 4'd1;
  localparam logic [3:0]       A_THRESH = 4'd14;
  localparam logic [3:0]       A_STATUS = 4'd15;

  logic                      req_seen, accept, wr, rd, ctrl_wr, clr, snap, en, count_en;
  logic [CNT_W-1:0]          total, total_snap, total_next, thresh;
  logic                      total_ovf, irq_pend;
  logic [CH-1:0]             ch_ovf;
  logic [CH-1:0][CNT_W-1:0]  ch_snap;
  logic [31:0]               status, rd_mux;
  logic                      unused_wr_data;

  assign accept     = evb_cmd_request & ~req_seen;
  assign wr         = accept & (evb_cmd_wr_mask != 2'b00);
  assign rd         = accept & (evb_cmd_wr_mask == 2'b00);
  assign ctrl_wr    = wr & (evb_cmd_addr == A_CTRL);
  assign clr        = ctrl_wr & evb_cmd_wr_data[1];
  assign snap       = ctrl_wr & evb_cmd_wr_data[2];
  assign count_en   = en & ready;
  assign total_next = (total == CNT_MAX) ? total : total + CNT_ONE;
  assign unused_wr_data = ^evb_cmd_wr_data;

  // req_seen resets high: a request still held across reset release is not a new command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_seen        <= 1'b1;
      evb_cmd_finish  <= 1'b0;
      evb_cmd_rd_data <= '0;
      en              <= 1'b0;
    end else begin
      req_seen        <= evb_cmd_request;
      evb_cmd_finish  <= accept;
      evb_cmd_rd_data <= rd ? rd_mux : '0;
      if (ctrl_wr) en <= evb_cmd_wr_data[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total      <= '0;
      total_snap <= '0;
      total_ovf  <= 1'b0;
    end else begin
      if (snap) total_snap <= total;
      if (clr || !ready)  total <= '0;
      else if (count_en)  total <= total_next;
      if (clr) total_ovf <= 1'b0;
      else if (count_en && (total == CNT_MAX)) total_ovf <= 1'b1;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt, cnt_snap;
    logic             ovf, hit;
    assign hit = count_en & busy[i];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt      <= '0;
        cnt_snap <= '0;
        ovf      <= 1'b0;
      end else begin
        if (snap) cnt_snap <= cnt;
        if (clr || !ready) cnt <= '0;
        else if (hit && (cnt != CNT_MAX)) cnt <= cnt + CNT_ONE;
        if (clr) ovf <= 1'b0;
        else if (hit && (cnt == CNT_MAX)) ovf <= 1'b1;
      end
    end
    assign ch_snap[i] = cnt_snap;
    assign ch_ovf[i]  = ovf;
  end

`ifdef PERF_MON_IRQ_EN
  // A threshold crossing wins over a same-cycle acknowledge so no event is lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh   <= '0;
      irq_pend <= 1'b0;
    end else begin
      if (wr && (evb_cmd_addr == A_THRESH)) thresh <= evb_cmd_wr_data[CNT_W-1:0];
      if (count_en && !clr && (thresh != '0) && (total_next == thresh))
        irq_pend <= 1'b1;
      else if (clr || (wr && (evb_cmd_addr == A_STATUS) && evb_cmd_wr_data[16]))
        irq_pend <= 1'b0;
    end
  end
  assign irq = irq_pend;
`else
  assign thresh   = '0;
  assign irq_pend = 1'b0;
`endif

  always_comb begin
    status          = '0;
    status[CH-1:0]  = ch_ovf;
    status[15]      = total_ovf;
    status[16]      = irq_pend;
  end

  always_comb begin
    rd_mux = '0;
    case (evb_cmd_addr)
      A_CTRL:   rd_mux[0]         = en;
      A_TOTAL:  rd_mux[CNT_W-1:0] = total_snap;
      A_THRESH: rd_mux[CNT_W-1:0] = thresh;
      A_STATUS: rd_mux            = status;
      default: begin
        for (int i = 0; i < CH; i++)
          if (evb_cmd_addr == 4'(i + 2)) rd_mux[CNT_W-1:0] = ch_snap[i];
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_perf_mon.sv
`default_nettype none
// Self-checking bench for perf_mon (CH=4, CNT_W=8): register tables plus
// hand-written sequences for snapshot, clear, ready-drop, reset and irq.
module tb_perf_mon;

  localparam int CH    = 4;
  localparam int CNT_W = 8;

  logic          clk = 1'b0;
  logic          rst_n, ready, req;
  logic [CH-1:0] busy;
  logic [3:0]    addr;
  logic [1:0]    mask;
  logic [31:0]   wdata, rdata;
  logic          finish;
`ifdef PERF_MON_IRQ_EN
  logic          irq;
`endif

  perf_mon #(.CH(CH), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ready           (ready),
    .busy            (busy),
    .evb_cmd_request (req),
    .evb_cmd_addr    (addr),
    .evb_cmd_wr_mask (mask),
    .evb_cmd_wr_data (wdata),
    .evb_cmd_finish  (finish),
    .evb_cmd_rd_data (rdata)
`ifdef PERF_MON_IRQ_EN
    ,
    .irq             (irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_read;
    logic [3:0]  addr;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    logic [3:0]  addr;
    logic        wr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  sb_t sb[$];
  int  ntests = 0;
  int  nfail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every finish pulse must match a queued command
  always @(negedge clk) begin
    if (rst_n && finish) begin
      if (sb.size() == 0) begin
        check("unexpected_finish", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        if (e.is_read) check($sformatf("rd_addr%0d", e.addr), rdata, e.exp);
      end
    end
  end

  // One EVB command: request sampled on the next rising edge, finish checked one cycle later
  task automatic evb(input logic [3:0] a, input logic is_wr, input logic [31:0] d,
                     input logic [31:0] exp);
    sb_t e;
    @(negedge clk);
    check("finish_idle", {31'd0, finish}, 32'd0);
    req   = 1'b1;
    addr  = a;
    mask  = is_wr ? 2'b11 : 2'b00;
    wdata = d;
    e.is_read = ~is_wr;
    e.addr    = a;
    e.exp     = exp;
    sb.push_back(e);
    @(negedge clk);
    check($sformatf("finish_pulse_addr%0d", a), {31'd0, finish}, 32'd1);
    req  = 1'b0;
    mask = 2'b00;
  endtask

  task automatic run_vec(input vec_t v);
    evb(v.addr, v.wr, v.data, v.exp);
  endtask

  vec_t t30[15];
  vec_t t31[6];
  vec_t t32a[4];
  vec_t t32b[3];
  vec_t t33[4];
  vec_t t34[16];

  initial begin
    t30[0]  = '{4'd1,  1'b0, 32'd0,   32'd100};
    t30[1]  = '{4'd2,  1'b0, 32'd0,   32'd100};
    t30[2]  = '{4'd3,  1'b0, 32'd0,   32'd0};
    t30[3]  = '{4'd4,  1'b0, 32'd0,   32'd100};
    t30[4]  = '{4'd5,  1'b0, 32'd0,   32'd0};
    t30[5]  = '{4'd6,  1'b0, 32'd0,   32'd0};
    t30[6]  = '{4'd13, 1'b0, 32'd0,   32'd0};
    t30[7]  = '{4'd0,  1'b0, 32'd0,   32'd1};
    t30[8]  = '{4'd1,  1'b1, 32'hFF,  32'd0};
    t30[9]  = '{4'd1,  1'b0, 32'd0,   32'd100};
    t30[10] = '{4'd15, 1'b0, 32'd0,   32'd0};
    t30[11] = '{4'd14, 1'b1, 32'd16,  32'd0};
`ifdef PERF_MON_IRQ_EN
    t30[12] = '{4'd14, 1'b0, 32'd0,   32'd16};
`else
    t30[12] = '{4'd14, 1'b0, 32'd0,   32'd0};
`endif
    t30[13] = '{4'd14, 1'b1, 32'd0,   32'd0};
    t30[14] = '{4'd14, 1'b0, 32'd0,   32'd0};

    t31[0] = '{4'd1,  1'b0, 32'd0, 32'd255};
    t31[1] = '{4'd2,  1'b0, 32'd0, 32'd255};
    t31[2] = '{4'd3,  1'b0, 32'd0, 32'd0};
    t31[3] = '{4'd4,  1'b0, 32'd0, 32'd0};
    t31[4] = '{4'd5,  1'b0, 32'd0, 32'd0};
    t31[5] = '{4'd15, 1'b0, 32'd0, 32'h0000_8001};

    t32a[0] = '{4'd1,  1'b0, 32'd0, 32'd50};
    t32a[1] = '{4'd2,  1'b0, 32'd0, 32'd50};
    t32a[2] = '{4'd4,  1'b0, 32'd0, 32'd0};
    t32a[3] = '{4'd15, 1'b0, 32'd0, 32'd0};

    t32b[0] = '{4'd1,  1'b0, 32'd0, 32'd1};
    t32b[1] = '{4'd2,  1'b0, 32'd0, 32'd1};
    t32b[2] = '{4'd15, 1'b0, 32'd0, 32'd0};

    t33[0] = '{4'd1,  1'b0, 32'd0, 32'd10};
    t33[1] = '{4'd2,  1'b0, 32'd0, 32'd10};
    t33[2] = '{4'd15, 1'b0, 32'd0, 32'd0};
    t33[3] = '{4'd0,  1'b0, 32'd0, 32'd1};

    for (int i = 0; i < 16; i++) t34[i] = '{4'(i), 1'b0, 32'd0, 32'd0};

    rst_n = 1'b0; ready = 1'b0; busy = '0;
    req = 1'b0; addr = '0; mask = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_finish", {31'd0, finish}, 32'd0);
    check("reset_rd_data", rdata, 32'd0);
    rst_n = 1'b1;
    evb(4'd0,  1'b0, 32'd0, 32'd0);
    evb(4'd15, 1'b0, 32'd0, 32'd0);

    // Basic counting: 100 cycles with channels 0 and 2 busy
    ready = 1'b1; busy = 4'b0101;
    evb(4'd0, 1'b1, 32'd1, 32'd0);
    repeat (99) @(negedge clk);
    evb(4'd0, 1'b1, 32'd5, 32'd0);
    for (int i = 0; i < 15; i++) run_vec(t30[i]);

    // Saturation at 8 bits
    busy = 4'b0001;
    evb(4'd0, 1'b1, 32'd3, 32'd0);
    repeat (299) @(negedge clk);
    evb(4'd0, 1'b1, 32'd5, 32'd0);
    for (int i = 0; i < 6; i++) run_vec(t31[i]);

    // SNAP+CLR together captures pre-clear values
    evb(4'd0, 1'b1, 32'd3, 32'd0);
    repeat (49) @(negedge clk);
    evb(4'd0, 1'b1, 32'd7, 32'd0);
    for (int i = 0; i < 4; i++) run_vec(t32a[i]);
    evb(4'd0, 1'b1, 32'd3, 32'd0);
    repeat (49) @(negedge clk);
    evb(4'd0, 1'b1, 32'd7, 32'd0);
    evb(4'd0, 1'b1, 32'd5, 32'd0);
    for (int i = 0; i < 3; i++) run_vec(t32b[i]);

    // ready drop clears live counters but leaves snapshots alone
    evb(4'd0, 1'b1, 32'd3, 32'd0);
    repeat (20) @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    ready = 1'b1;
    evb(4'd1, 1'b0, 32'd0, 32'd1);
    repeat (7) @(negedge clk);
    evb(4'd0, 1'b1, 32'd5, 32'd0);
    for (int i = 0; i < 4; i++) run_vec(t33[i]);

    // Unmapped read, then asynchronous reset during a command
    evb(4'd13, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    req = 1'b1; addr = 4'd0; mask = 2'b00;
    @(posedge clk);
    #1;
    check("pre_reset_finish", {31'd0, finish}, 32'd1);
    check("pre_reset_rd_data", rdata, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_finish", {31'd0, finish}, 32'd0);
    check("async_reset_rd_data", rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_finish_after_reset", {31'd0, finish}, 32'd0);
    end
    req = 1'b0;
    for (int i = 0; i < 16; i++) run_vec(t34[i]);

`ifdef PERF_MON_IRQ_EN
    evb(4'd14, 1'b1, 32'd16, 32'd0);
    evb(4'd0,  1'b1, 32'd1,  32'd0);
    repeat (15) @(negedge clk);
    check("irq_before_thresh", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("irq_at_thresh", {31'd0, irq}, 32'd1);
    evb(4'd15, 1'b0, 32'd0, 32'h0001_0000);
    evb(4'd15, 1'b1, 32'h0001_0000, 32'd0);
    check("irq_after_ack", {31'd0, irq}, 32'd0);
    evb(4'd15, 1'b0, 32'd0, 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire
